// File: rtl/model_trainer_fnn_sgd_update.sv
// Streaming SGD / SGD-with-momentum weight updater: one W/dW/V element per cycle,
// two-stage saturating fixed-point pipeline with row/column indices carried alongside.
module model_trainer_fnn_sgd_update #(
   parameter int DATA_SIZE    = 64,
   parameter int CONTROL_SIZE = 64,
   parameter int FRAC_BITS    = 32,
   parameter int PIPE_DEPTH   = 2
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    START,
   output logic                    READY,
   input  logic                    MODE,
   input  logic [CONTROL_SIZE-1:0] SIZE_I_IN,
   input  logic [CONTROL_SIZE-1:0] SIZE_J_IN,
   input  logic [DATA_SIZE-1:0]    LEARNING_RATE,
   input  logic [DATA_SIZE-1:0]    MOMENTUM,
   input  logic                    W_IN_ENABLE,
   input  logic [DATA_SIZE-1:0]    W_IN,
   input  logic [DATA_SIZE-1:0]    DW_IN,
   input  logic [DATA_SIZE-1:0]    V_IN,
   output logic                    W_OUT_ENABLE,
   output logic [DATA_SIZE-1:0]    W_OUT,
   output logic [DATA_SIZE-1:0]    V_OUT,
   output logic [CONTROL_SIZE-1:0] INDEX_I_OUT,
   output logic [CONTROL_SIZE-1:0] INDEX_J_OUT,
   output logic                    SATURATED
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam int DCW = $clog2(PIPE_DEPTH + 1);

   localparam logic [DATA_SIZE-1:0] MAX_VAL = {1'b0, {(DATA_SIZE-1){1'b1}}};
   localparam logic [DATA_SIZE-1:0] MIN_VAL = {1'b1, {(DATA_SIZE-1){1'b0}}};

   // Results are {clamped, value}.
   function automatic logic [DATA_SIZE:0] mul_sat(input logic [DATA_SIZE-1:0] a,
                                                  input logic [DATA_SIZE-1:0] b);
      logic signed [2*DATA_SIZE-1:0] ax;
      logic signed [2*DATA_SIZE-1:0] bx;
      logic signed [2*DATA_SIZE-1:0] p;
      ax = {{DATA_SIZE{a[DATA_SIZE-1]}}, a};
      bx = {{DATA_SIZE{b[DATA_SIZE-1]}}, b};
      p  = (ax * bx) >>> FRAC_BITS;
      if ((&p[2*DATA_SIZE-1:DATA_SIZE-1]) || !(|p[2*DATA_SIZE-1:DATA_SIZE-1]))
         mul_sat = {1'b0, p[DATA_SIZE-1:0]};
      else if (p[2*DATA_SIZE-1])
         mul_sat = {1'b1, MIN_VAL};
      else
         mul_sat = {1'b1, MAX_VAL};
   endfunction

   function automatic logic [DATA_SIZE:0] addsub_sat(input logic [DATA_SIZE-1:0] a,
                                                     input logic [DATA_SIZE-1:0] b,
                                                     input logic               sub);
      logic [DATA_SIZE:0] s;
      if (sub)
         s = {a[DATA_SIZE-1], a} - {b[DATA_SIZE-1], b};
      else
         s = {a[DATA_SIZE-1], a} + {b[DATA_SIZE-1], b};
      if (s[DATA_SIZE] != s[DATA_SIZE-1])
         addsub_sat = {1'b1, (s[DATA_SIZE] ? MIN_VAL : MAX_VAL)};
      else
         addsub_sat = {1'b0, s[DATA_SIZE-1:0]};
   endfunction

   logic [1:0]              state;
   logic [DCW-1:0]          drain_cnt;
   logic [CONTROL_SIZE-1:0] size_i_q;
   logic [CONTROL_SIZE-1:0] size_j_q;
   logic [CONTROL_SIZE-1:0] idx_i;
   logic [CONTROL_SIZE-1:0] idx_j;
   logic [DATA_SIZE-1:0]    lr_q;
   logic [DATA_SIZE-1:0]    mu_q;
   logic                    mode_q;

   logic                    s1_valid;
   logic [DATA_SIZE-1:0]    s1_g;
   logic [DATA_SIZE-1:0]    s1_m;
   logic [DATA_SIZE-1:0]    s1_w;
   logic [CONTROL_SIZE-1:0] s1_i;
   logic [CONTROL_SIZE-1:0] s1_j;
   logic                    s1_sat;

   logic                    accept;
   logic                    start_accept;
   logic                    last_elem;
   logic                    j_wrap;
   logic [DATA_SIZE:0]      g_res;
   logic [DATA_SIZE:0]      m_res;
   logic [DATA_SIZE:0]      v_res;
   logic [DATA_SIZE:0]      w_res;

   assign READY = (state == ST_DONE);

   always_comb begin
      accept       = (state == ST_RUN) && W_IN_ENABLE;
      start_accept = (state == ST_IDLE) && START;
      j_wrap       = (idx_j == size_j_q - CONTROL_SIZE'(1));
      last_elem    = j_wrap && (idx_i == size_i_q - CONTROL_SIZE'(1));
      g_res        = mul_sat(DW_IN, lr_q);
      m_res        = mode_q ? mul_sat(V_IN, mu_q) : '0;
      v_res        = addsub_sat(s1_m, s1_g, 1'b0);
      w_res        = addsub_sat(s1_w, v_res[DATA_SIZE-1:0], 1'b1);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= ST_IDLE;
         drain_cnt <= '0;
         size_i_q  <= '0;
         size_j_q  <= '0;
         idx_i     <= '0;
         idx_j     <= '0;
         lr_q      <= '0;
         mu_q      <= '0;
         mode_q    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (START) begin
                  size_i_q <= SIZE_I_IN;
                  size_j_q <= SIZE_J_IN;
                  lr_q     <= LEARNING_RATE;
                  mu_q     <= MOMENTUM;
                  mode_q   <= MODE;
                  idx_i    <= '0;
                  idx_j    <= '0;
                  state    <= (SIZE_I_IN == '0 || SIZE_J_IN == '0) ? ST_DONE : ST_RUN;
               end
            end
            ST_RUN: begin
               if (accept) begin
                  if (j_wrap) begin
                     idx_j <= '0;
                     idx_i <= idx_i + CONTROL_SIZE'(1);
                  end else begin
                     idx_j <= idx_j + CONTROL_SIZE'(1);
                  end
                  // DRAIN covers the cycles the last element still spends in the pipe.
                  if (last_elem) begin
                     state     <= ST_DRAIN;
                     drain_cnt <= DCW'(PIPE_DEPTH - 1);
                  end
               end
            end
            ST_DRAIN: begin
               if (drain_cnt == '0)
                  state <= ST_DONE;
               else
                  drain_cnt <= drain_cnt - DCW'(1);
            end
            ST_DONE:  state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         s1_valid     <= 1'b0;
         s1_g         <= '0;
         s1_m         <= '0;
         s1_w         <= '0;
         s1_i         <= '0;
         s1_j         <= '0;
         s1_sat       <= 1'b0;
         W_OUT_ENABLE <= 1'b0;
         W_OUT        <= '0;
         V_OUT        <= '0;
         INDEX_I_OUT  <= '0;
         INDEX_J_OUT  <= '0;
         SATURATED    <= 1'b0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_g   <= g_res[DATA_SIZE-1:0];
            s1_m   <= m_res[DATA_SIZE-1:0];
            s1_w   <= W_IN;
            s1_i   <= idx_i;
            s1_j   <= idx_j;
            s1_sat <= g_res[DATA_SIZE] | m_res[DATA_SIZE];
         end
         W_OUT_ENABLE <= s1_valid;
         if (s1_valid) begin
            W_OUT       <= w_res[DATA_SIZE-1:0];
            V_OUT       <= v_res[DATA_SIZE-1:0];
            INDEX_I_OUT <= s1_i;
            INDEX_J_OUT <= s1_j;
         end
         // Stage-1 clamps ride with the element so the flag rises together with W_OUT.
         if (start_accept)
            SATURATED <= 1'b0;
         else if (s1_valid && (s1_sat || v_res[DATA_SIZE] || w_res[DATA_SIZE]))
            SATURATED <= 1'b1;
      end
   end

endmodule
